// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizing and slicing helpers for the scoreboarded register file
package reg_file_pkg;

  // Address width for an NREG-entry file; never narrower than one bit.
  function automatic int aw_of(input int nreg);
    return (nreg > 2) ? $clog2(nreg) : 1;
  endfunction

  // Highest value a pending counter can hold; reservations stall there.
  function automatic int cnt_sat(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  // Width needed to count how many write ports release one register at once.
  function automatic int dec_w_of(input int nwp);
    return (nwp > 1) ? $clog2(nwp + 1) : 1;
  endfunction

  // Low bit of port idx inside a packed per-port vector of the given field width.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read, write, reserve and flush bundle of the register file
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2
);
  import reg_file_pkg::*;

  localparam int AW = aw_of(NREG);

  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic [NWP-1:0]      we;
  logic [NWP-1:0]      wrel;
  logic [NWP*AW-1:0]   waddr;
  logic [NWP*XLEN-1:0] wdata;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic                flush;

  modport master (
    output raddr, we, wrel, waddr, wdata, rsv_valid, rsv_addr, flush,
    input  rdata, rbusy, rsv_ready
  );

  modport slave (
    input  raddr, we, wrel, waddr, wdata, rsv_valid, rsv_addr, flush,
    output rdata, rbusy, rsv_ready
  );

endinterface

// File: rtl/rf_pend_cnt.sv
// rtl/rf_pend_cnt.sv - saturating up/down pending-write counter for one register
module rf_pend_cnt #(
  parameter int CNT_W = 2,
  parameter int DW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [DW-1:0]    dec_count,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // One spare bit so the increment and the release total never wrap.
  localparam int SW = ((CNT_W > DW) ? CNT_W : DW) + 1;

  logic [SW-1:0] up;
  logic [SW-1:0] dn;

  always_comb begin
    up = SW'(count) + SW'(inc && (count != '1));
    dn = SW'(dec_count);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (dn >= up) begin
      count <= '0;
    end else begin
      count <= CNT_W'(up - dn);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port integer register file with pending-write scoreboard
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_sb_if.slave bus
);

  localparam int AW  = aw_of(NREG);
  localparam int DW  = dec_w_of(NWP);
  localparam int SAT = cnt_sat(CNT_W);

  logic [XLEN-1:0]                 mem [NREG];
  logic [NREG-1:0][CNT_W-1:0]      cnt;
  logic [DW-1:0]                   rel_cnt [NREG];
  logic [AW-1:0]                   wa [NWP];
  logic [XLEN-1:0]                 wd [NWP];
  logic                            rsv_ready;
  logic                            rsv_fire;

  for (genvar j = 0; j < NWP; j++) begin : g_wport
    assign wa[j] = bus.waddr[slice_lo(j, AW) +: AW];
    assign wd[j] = bus.wdata[slice_lo(j, XLEN) +: XLEN];
  end

  // Number of write ports releasing each register this cycle.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      rel_cnt[r] = '0;
    end
    for (int j = 0; j < NWP; j++) begin
      if (bus.we[j] && bus.wrel[j] && (wa[j] != '0)) begin
        rel_cnt[wa[j]] = rel_cnt[wa[j]] + DW'(1);
      end
    end
  end

  // Ready looks only at the registered count, never at this cycle's releases.
  assign rsv_ready     = reset || (bus.rsv_addr == '0) || (cnt[bus.rsv_addr] != CNT_W'(SAT));
  assign rsv_fire      = bus.rsv_valid && rsv_ready && !bus.flush;
  assign bus.rsv_ready = rsv_ready;

  assign cnt[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    rf_pend_cnt #(
      .CNT_W(CNT_W),
      .DW   (DW)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (rsv_fire && (bus.rsv_addr == AW'(r))),
      .dec_count(rel_cnt[r]),
      .clr      (bus.flush),
      .count    (cnt[r])
    );
  end

  // Later ports override earlier ones, so the highest-index writer wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (bus.we[j] && (wa[j] != '0)) begin
          mem[wa[j]] <= wd[j];
        end
      end
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rport
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = bus.raddr[slice_lo(i, AW) +: AW];

    always_comb begin
      d = mem[a];
      b = (cnt[a] != '0);
      if (BYPASS != 0) begin
        for (int j = 0; j < NWP; j++) begin
          if (bus.we[j] && (wa[j] == a)) begin
            d = wd[j];
          end
        end
        b = int'(cnt[a]) > int'(rel_cnt[a]);
      end
      if (reset || (a == '0)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign bus.rdata[slice_lo(i, XLEN) +: XLEN] = d;
    assign bus.rbusy[i] = b;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - bench for reg_file_sb, bypassed and non-bypassed builds side by side
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus1 ();
  reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus0 ();

  assign bus0.raddr     = bus1.raddr;
  assign bus0.we        = bus1.we;
  assign bus0.wrel      = bus1.wrel;
  assign bus0.waddr     = bus1.waddr;
  assign bus0.wdata     = bus1.wdata;
  assign bus0.rsv_valid = bus1.rsv_valid;
  assign bus0.rsv_addr  = bus1.rsv_addr;
  assign bus0.flush     = bus1.flush;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .CNT_W(2), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .CNT_W(2), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: register contents and outstanding reservations per register.
  logic [31:0] m_mem [NREG];
  int          m_cnt [NREG];

  typedef struct {
    bit        rst;
    bit [1:0]  we;
    bit [1:0]  wrel;
    bit [4:0]  wa0, wa1;
    bit [31:0] wd0, wd1;
    bit        rv;
    bit [4:0]  rsa;
    bit        fl;
    bit [4:0]  ra0;
    bit [31:0] e_d1, e_d0;
    bit        e_b1, e_b0, e_rdy;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit [1:0] we, input bit [1:0] wrel,
                       input bit [4:0] wa0, input bit [4:0] wa1,
                       input bit [31:0] wd0, input bit [31:0] wd1,
                       input bit rv, input bit [4:0] rsa, input bit fl,
                       input bit [4:0] ra0, input bit [4:0] ra1);
    reset          = rst;
    bus1.we        = we;
    bus1.wrel      = wrel;
    bus1.waddr     = {wa1, wa0};
    bus1.wdata     = {wd1, wd0};
    bus1.rsv_valid = rv;
    bus1.rsv_addr  = rsa;
    bus1.flush     = fl;
    bus1.raddr     = {ra1, ra0};
  endtask

  // Compares every output of both builds against the reference, then advances the reference.
  task automatic model_step(input int row);
    int          rel [NREG];
    bit          rdy;
    logic [4:0]  a, wa [NWP];
    logic [31:0] wd [NWP];
    logic [31:0] e0, e1;
    bit          eb0, eb1;
    int          n;
    for (int r = 0; r < NREG; r++) rel[r] = 0;
    for (int j = 0; j < NWP; j++) begin
      wa[j] = bus1.waddr[j*AW +: AW];
      wd[j] = bus1.wdata[j*XLEN +: XLEN];
      if (bus1.we[j] && bus1.wrel[j] && wa[j] != 0) rel[wa[j]]++;
    end
    rdy = reset || bus1.rsv_addr == 0 || m_cnt[bus1.rsv_addr] < CMAX;
    chk("m_rsv_ready_bp1", row, {31'd0, bus1.rsv_ready}, {31'd0, rdy});
    chk("m_rsv_ready_bp0", row, {31'd0, bus0.rsv_ready}, {31'd0, rdy});
    for (int i = 0; i < NRP; i++) begin
      a   = bus1.raddr[i*AW +: AW];
      e0  = (reset || a == 0) ? 32'd0 : m_mem[a];
      e1  = e0;
      if (!reset && a != 0)
        for (int j = 0; j < NWP; j++) if (bus1.we[j] && wa[j] == a) e1 = wd[j];
      eb0 = !reset && a != 0 && m_cnt[a] != 0;
      eb1 = !reset && a != 0 && (m_cnt[a] - rel[a]) > 0;
      chk($sformatf("m_rdata_bp1_p%0d", i), row, bus1.rdata[i*XLEN +: XLEN], e1);
      chk($sformatf("m_rdata_bp0_p%0d", i), row, bus0.rdata[i*XLEN +: XLEN], e0);
      chk($sformatf("m_rbusy_bp1_p%0d", i), row, {31'd0, bus1.rbusy[i]}, {31'd0, eb1});
      chk($sformatf("m_rbusy_bp0_p%0d", i), row, {31'd0, bus0.rbusy[i]}, {31'd0, eb0});
    end
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r] = 0;
        m_cnt[r] = 0;
      end
    end else begin
      for (int j = 0; j < NWP; j++) if (bus1.we[j] && wa[j] != 0) m_mem[wa[j]] = wd[j];
      for (int r = 1; r < NREG; r++) begin
        n = m_cnt[r] + ((bus1.rsv_valid && rdy && bus1.rsv_addr == r) ? 1 : 0) - rel[r];
        m_cnt[r] = bus1.flush ? 0 : (n < 0 ? 0 : n);
      end
    end
  endtask

  function automatic vec_t mk(bit rst, bit [1:0] we, bit [1:0] wrel, bit [4:0] wa0, bit [4:0] wa1,
                              bit [31:0] wd0, bit [31:0] wd1, bit rv, bit [4:0] rsa, bit fl,
                              bit [4:0] ra0, bit [31:0] e_d1, bit [31:0] e_d0,
                              bit e_b1, bit e_b0, bit e_rdy);
    vec_t v;
    v.rst = rst; v.we = we; v.wrel = wrel; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.rv = rv; v.rsa = rsa; v.fl = fl; v.ra0 = ra0;
    v.e_d1 = e_d1; v.e_d0 = e_d0; v.e_b1 = e_b1; v.e_b0 = e_b0; v.e_rdy = e_rdy;
    return v;
  endfunction

  function automatic bit [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    //              rst we    wrel  wa0 wa1 wd0           wd1    rv rsa fl ra0 | d1            d0            b1 b0 rdy
    tbl.push_back(mk(0, 2'b01, 2'b00, 5, 0, 32'hDEADBEEF, 0,     0, 0, 0, 5,    32'hDEADBEEF, 0,            0, 0, 1));
    tbl.push_back(mk(1, 2'b01, 2'b00, 5, 0, 32'h12345678, 0,     1, 5, 0, 6,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 5, 0, 5,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 32'hFFFFFFFF, 0,     1, 0, 0, 0,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 0, 0, 0,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b00, 7, 7, 32'h11,       32'h22, 0, 0, 0, 7,   32'h22,       0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 0, 0, 7,    32'h22,       32'h22,       0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 3, 0, 3,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 3, 0, 3,    0,            0,            1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 3, 0, 3,    0,            0,            1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 3, 0, 3,    0,            0,            1, 1, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 3, 0, 32'h33,       0,     0, 3, 0, 3,    32'h33,       0,            1, 1, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 3, 0, 3,    32'h33,       32'h33,       1, 1, 1));
    tbl.push_back(mk(0, 2'b11, 2'b11, 3, 3, 32'h44,       32'h55, 0, 3, 0, 3,   32'h55,       32'h33,       0, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 3, 0, 3,    32'h55,       32'h55,       0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 9, 0, 9,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b01, 2'b01, 9, 0, 32'h99,       0,     1, 9, 0, 9,    32'h99,       0,            0, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 9, 0, 9,    32'h99,       32'h99,       1, 1, 1));
    tbl.push_back(mk(0, 2'b11, 2'b11, 9, 9, 32'hA1,       32'hA2, 0, 9, 0, 9,   32'hA2,       32'h99,       0, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 9, 0, 9,    32'hA2,       32'hA2,       0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 1, 0, 1,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 2, 0, 1,    0,            0,            1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 4, 0, 2,    0,            0,            1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     1, 6, 1, 4,    0,            0,            1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 6, 0, 6,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 1, 0, 7,    32'h22,       32'h22,       0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 4, 0, 4,    0,            0,            0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,            0,     0, 2, 0, 3,    32'h55,       32'h55,       0, 0, 1));

    for (int r = 0; r < NREG; r++) begin
      m_mem[r] = 0;
      m_cnt[r] = 0;
    end

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      model_step(-1);
    end

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].rst, tbl[k].we, tbl[k].wrel, tbl[k].wa0, tbl[k].wa1, tbl[k].wd0, tbl[k].wd1,
            tbl[k].rv, tbl[k].rsa, tbl[k].fl, tbl[k].ra0, tbl[k].rsa);
      #2;
      chk("t_rdata_bp1", k, bus1.rdata[31:0], tbl[k].e_d1);
      chk("t_rdata_bp0", k, bus0.rdata[31:0], tbl[k].e_d0);
      chk("t_rbusy_bp1", k, {31'd0, bus1.rbusy[0]}, {31'd0, tbl[k].e_b1});
      chk("t_rbusy_bp0", k, {31'd0, bus0.rbusy[0]}, {31'd0, tbl[k].e_b0});
      chk("t_rsv_ready", k, {31'd0, bus1.rsv_ready}, {31'd0, tbl[k].e_rdy});
      model_step(k);
    end

    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      drive($urandom_range(0, 63) == 0, 2'($urandom), 2'($urandom), rnd_addr(), rnd_addr(),
            $urandom, $urandom, 1'($urandom), rnd_addr(), $urandom_range(0, 23) == 0,
            rnd_addr(), rnd_addr());
      #2;
      model_step(1000 + k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
